// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared FSM state type and byte-lane constants for the APB4 memory slave
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int WAIT_W = 4;
    localparam int BYTE_W = 8;

endpackage

// File: rtl/apb_sram_be.sv
// rtl/apb_sram_be.sv - single-port word array with per-byte write enable and asynchronous read
module apb_sram_be #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int AW         = 8
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [AW-1:0]           i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata
);
    import apb_pkg::*;

    localparam int NBYTES = DATA_WIDTH / BYTE_W;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (i_we && i_be[i]) begin
                r_mem[i_addr][i*BYTE_W +: BYTE_W] <= i_wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/apb4_mem_slave.sv
// rtl/apb4_mem_slave.sv - APB4 memory slave with wait states, PSLVERR and byte strobes
// Byte strobes are honoured only when APB4_MEM_SLAVE_PSTRB_EN is defined.
module apb4_mem_slave
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int NBYTES = DATA_WIDTH / BYTE_W;
    localparam int OFFS_W = $clog2(NBYTES);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                r_state, w_state_nxt;
    logic [WAIT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                  w_latch;
    logic                  r_write;
    logic                  r_err;
    logic [MEM_AW-1:0]     r_idx;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_misalign;
    logic                  w_oor;
    logic                  w_err;
    logic                  w_ready;
    logic                  w_commit;
    logic [NBYTES-1:0]     w_be;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Extra top bit keeps the range check exact even when DEPTH fills the index space.
    assign w_idx      = paddr >> OFFS_W;
    assign w_misalign = (paddr & ADDR_WIDTH'(NBYTES - 1)) != '0;
    assign w_oor      = {1'b0, w_idx} >= (ADDR_WIDTH + 1)'(DEPTH);
    assign w_err      = w_misalign | w_oor;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (psel && !penable) begin
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = WAIT_W'(WAIT_STATES);
                    w_latch     = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel || !penable) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_write <= pwrite;
                r_err   <= w_err;
                r_idx   <= w_idx[MEM_AW-1:0];
            end
        end
    end

    assign w_ready  = (r_state == ACCESS) && (r_cnt == '0) && penable;
    // Reset on the completing edge wins over the write.
    assign w_commit = w_ready && psel && r_write && !r_err && !rst;

`ifdef APB4_MEM_SLAVE_PSTRB_EN
    assign w_be = pstrb;
`else
    assign w_be = pstrb | {NBYTES{1'b1}};
`endif

    apb_sram_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (MEM_AW)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_commit),
        .i_be    (w_be),
        .i_addr  (r_idx),
        .i_wdata (pwdata),
        .o_rdata (w_rdata)
    );

    assign pready  = w_ready;
    assign pslverr = w_ready & r_err;
    assign prdata  = (w_ready && !r_write && !r_err) ? w_rdata : '0;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// tb/tb_apb4_mem_slave.sv - randomized self-checking bench for apb4_mem_slave
module tb_apb4_mem_slave;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 256;
    localparam int WS    = 2;
`ifdef APB4_MEM_SLAVE_PSTRB_EN
    localparam bit PSTRB = 1'b1;
`else
    localparam bit PSTRB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [3:0]    pstrb = '0;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    apb4_mem_slave #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    logic        exp_rdy = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rd = '0;
    logic [31:0] model [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (pready !== exp_rdy) begin
                n_bad++;
                $display("FAIL pready t=%0t got %b expected %b", $time, pready, exp_rdy);
            end
            n_cmp++;
            if (pslverr !== exp_err) begin
                n_bad++;
                $display("FAIL pslverr t=%0t got %b expected %b", $time, pslverr, exp_err);
            end
            n_cmp++;
            if (prdata !== exp_rd) begin
                n_bad++;
                $display("FAIL prdata t=%0t got %h expected %h", $time, prdata, exp_rd);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", name, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_exp();
        exp_rdy = 1'b0;
        exp_err = 1'b0;
        exp_rd  = '0;
    endtask

    task automatic idle();
        step();
        psel    = 1'b0;
        penable = 1'b0;
        idle_exp();
    endtask

    function automatic bit is_bad(input logic [AW-1:0] a);
        return (a[1:0] != 2'b00) || (int'(a >> 2) >= DEPTH);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (s[b] || !PSTRB) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    // One full transfer; abort_k >= 0 drops psel in that access cycle instead.
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int abort_k,
                        output logic [31:0] rd, output logic err);
        rd  = '0;
        err = 1'b0;
        step();
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = $urandom;
        pstrb   = 4'($urandom);
        idle_exp();
        for (int k = 0; k <= WS; k++) begin
            step();
            if (k == abort_k) begin
                psel    = 1'b0;
                penable = 1'b0;
                paddr   = AW'($urandom);
                idle_exp();
                return;
            end
            penable = 1'b1;
            if (k < WS) begin
                paddr  = AW'($urandom);
                pwrite = 1'($urandom);
                pwdata = $urandom;
                pstrb  = 4'($urandom);
                idle_exp();
            end else begin
                pwdata  = d;
                pstrb   = s;
                exp_rdy = 1'b1;
                exp_err = is_bad(a);
                exp_rd  = (!wr && !is_bad(a)) ? model[int'(a >> 2)] : 32'h0;
                @(negedge clk);
                rd  = prdata;
                err = pslverr;
                if (wr && !is_bad(a)) model[int'(a >> 2)] = merge(model[int'(a >> 2)], d, s);
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          c0;
        logic [AW-1:0] a;

        chk_en = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        idle();

        for (int i = 0; i < DEPTH; i++) begin
            xfer(1'b1, AW'(i * 4), $urandom, 4'hF, -1, rd, er);
        end
        idle();

        xfer(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, -1, rd, er);
        xfer(1'b0, 12'h010, 32'h0, 4'h0, -1, rd, er);
        chk("rd_010", rd, 32'hDEADBEEF);
        chk("err_010", {31'h0, er}, 32'h0);

        xfer(1'b1, 12'h030, 32'h11223344, 4'hF, -1, rd, er);
        xfer(1'b1, 12'h030, 32'hAABBCCDD, 4'b0101, -1, rd, er);
        xfer(1'b0, 12'h030, 32'h0, 4'h0, -1, rd, er);
        chk("strb_030", rd, PSTRB ? 32'h11BB33DD : 32'hAABBCCDD);

        xfer(1'b1, 12'h000, 32'hCAFEF00D, 4'hF, -1, rd, er);
        xfer(1'b1, 12'h400, 32'h55555555, 4'hF, -1, rd, er);
        chk("err_oor", {31'h0, er}, 32'h1);
        xfer(1'b0, 12'h000, 32'h0, 4'h0, -1, rd, er);
        chk("no_alias_000", rd, 32'hCAFEF00D);
        xfer(1'b0, 12'h002, 32'h0, 4'h0, -1, rd, er);
        chk("err_misalign", {31'h0, er}, 32'h1);
        chk("rd_misalign", rd, 32'h0);
        idle();

        xfer(1'b1, 12'h040, 32'h12345678, 4'hF, -1, rd, er);
        xfer(1'b1, 12'h040, 32'h87654321, 4'hF, 1, rd, er);
        idle();
        xfer(1'b0, 12'h040, 32'h0, 4'h0, -1, rd, er);
        chk("abort_040", rd, 32'h12345678);

        // Reset arrives on the edge that would commit the write.
        xfer(1'b1, 12'h050, 32'h0BADCAFE, 4'hF, -1, rd, er);
        step();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h050;
        idle_exp();
        for (int k = 0; k <= WS; k++) begin
            step();
            penable = 1'b1;
            idle_exp();
            if (k == WS) begin
                pwdata  = 32'hFFFFFFFF;
                pstrb   = 4'hF;
                rst     = 1'b1;
                exp_rdy = 1'b1;
            end
        end
        step();
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        idle_exp();
        #1;
        @(negedge clk);
        chk("rst_pready", {31'h0, pready}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        xfer(1'b0, 12'h050, 32'h0, 4'h0, -1, rd, er);
        chk("rst_drop_050", rd, 32'h0BADCAFE);
        idle();

        c0 = cyc;
        xfer(1'b1, 12'h060, 32'h600DF00D, 4'hF, -1, rd, er);
        xfer(1'b0, 12'h060, 32'h0, 4'h0, -1, rd, er);
        chk("b2b_data", rd, 32'h600DF00D);
        chk("b2b_cycles", 32'(cyc - c0), 32'(2 * (2 + WS)));

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) a = AW'($urandom);
            else a = AW'($urandom_range(0, DEPTH - 1) * 4);
            xfer(1'($urandom), a, $urandom, 4'($urandom),
                 ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, WS)) : -1, rd, er);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        idle();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb4_mem_slave.md
# apb4_mem_slave

Parametrised APB4 memory-mapped slave: a word-organised register/memory array behind an APB completer port, with configurable wait states, error response on bad addresses and byte-lane write strobes. It is the next generation of the team's 8-bit APB memory slave: generalised in data width, depth and latency, and it adds PSLVERR. It sits on an APB bridge output as a generic scratch/config memory target.

## Interface
- DATA_WIDTH, 32: bus data width; must be 8, 16, 32 or 64.
- ADDR_WIDTH, 12: PADDR width (byte address).
- DEPTH, 256: number of DATA_WIDTH words; must be ≤ 2^(ADDR_WIDTH−log2(DATA_WIDTH/8)).
- WAIT_STATES, 0: wait cycles inserted in every access phase, 0..15.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- psel  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  write byte strobes.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  error response, valid only with pready.

## Operation
- Word index = paddr >> log2(DATA_WIDTH/8). Error condition: word index ≥ DEPTH, or paddr low (byte-offset) bits ≠ 0.
- FSM states: IDLE, ACCESS.
  - IDLE: psel & !penable → ACCESS; latch addr, pwrite, error flag; load wait counter with WAIT_STATES. Otherwise stay in IDLE.
  - ACCESS, penable=1, counter>0: decrement; stay.
  - ACCESS, penable=1, counter=0: complete; → IDLE.
  - ACCESS, psel=0 or penable=0 (master abort/protocol violation): → IDLE; no write; no response.
- pready = (state==ACCESS) & (counter==0) & penable; driven from registers plus penable only.
- pslverr = pready & latched error flag.
- Write commits at the completing edge, only if no error. Byte lane i is written iff pstrb[i], with pwdata sampled at that edge. Reads ignore pstrb.
- prdata = mem[latched index] when pready & !pwrite & !error; otherwise 0.
- Memory contents are not reset.

## Timing
- Reset values: pready=0, pslverr=0, prdata=0, state=IDLE, counter=0.
- Cycle T0 is the setup cycle (psel=1, penable=0). With WAIT_STATES=N, pready is asserted in cycle T1+N; the transfer ends at the rising edge closing that cycle.
- N=0 gives a zero-wait transfer: pready is high in the first access cycle.
- Back-to-back transfers: the new setup cycle immediately follows the completion cycle, so the minimum is 2 cycles per transfer.
- Read-after-write to the same word returns the new data in the next transfer.
- rst asserted mid-ACCESS: at the next edge go to IDLE with outputs at reset values; a pending write is dropped.
- Address/control changes during ACCESS are ignored; latched values are used. pwdata and pstrb are sampled at completion.

## Configuration
- APB4_MEM_SLAVE_PSTRB_EN defined: pstrb is honoured per byte lane.
- Not defined: the pstrb port remains but is ignored; every completed non-error write updates all bytes.

## Structure
- Shared package apb_pkg holds:
  - the FSM state typedef {IDLE, ACCESS};
  - the WAIT_STATES width constant (4);
  - the byte-lane helper localparams.
- Sub-module apb_sram_be: single-port DEPTH×DATA_WIDTH array with per-byte write enable and asynchronous read. The FSM, counter and error logic stay in the top.

## Test plan
- Zero wait, DATA_WIDTH=32: write 0xDEADBEEF to 0x010 with pstrb=0xF, then read 0x010 → pready in the first access cycle, prdata=0xDEADBEEF, pslverr=0.
- WAIT_STATES=3: read of 0x004 → pready low for 3 access cycles and high in the 4th; prdata is 0 while pready=0.
- Byte strobes (macro on): preload 0x11223344, write 0xAABBCCDD with pstrb=0b0101 → readback 0x11BB33DD. Macro off → readback 0xAABBCCDD.
- Errors: write to word index DEPTH (0x400 at DEPTH=256) → pready=1, pslverr=1, memory unchanged. Misaligned read at 0x002 → pslverr=1, prdata=0.
- Abort and reset: deassert psel mid-wait (WAIT_STATES=2) → FSM back to IDLE and the write is not applied. Assert rst during ACCESS → next cycle pready=0, pslverr=0, prdata=0, and the write is not applied.
- Back-to-back write then read of the same address with no idle cycle → read returns the written data; each transfer takes 2+WAIT_STATES cycles.
